// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: segment vector type, blank pattern and
// the active-low hex glyph table used by every display block in the core.
package seg7_pkg;

    typedef logic [6:0] seg_t;

    localparam int PWM_W = 4;

    localparam seg_t SEG_OFF = 7'h7F;

    // {a,b,c,d,e,f,g}, a = MSB, active-low
    localparam seg_t HEX2SEG [16] = '{
        7'h01, 7'h4F, 7'h12, 7'h06,
        7'h4C, 7'h24, 7'h20, 7'h0F,
        7'h00, 7'h04, 7'h08, 7'h60,
        7'h31, 7'h42, 7'h30, 7'h38
    };

    function automatic seg_t hex2seg(input logic [3:0] nibble);
        return HEX2SEG[nibble];
    endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Register-side load bus of the seven-segment scanner: shadowed digit data
// plus the live brightness setting.
interface seg7_scan_ctrl_if #(
    parameter int NUM_DIGITS = 8
);

    logic                    i_load;
    logic [4*NUM_DIGITS-1:0] i_value;
    logic [NUM_DIGITS-1:0]   i_dp;
    logic [NUM_DIGITS-1:0]   i_digit_en;
    logic [3:0]              i_bright;

    modport master (
        output i_load,
        output i_value,
        output i_dp,
        output i_digit_en,
        output i_bright
    );

    modport slave (
        input i_load,
        input i_value,
        input i_dp,
        input i_digit_en,
        input i_bright
    );

endinterface

// File: rtl/seg7_hex_decoder.sv
// Combinational hex nibble to active-low segment pattern.
module seg7_hex_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output seg_t       seg
);

    assign seg = hex2seg(nibble);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed N-digit seven-segment scanner with ghost blanking, PWM dimming
// and frame-synchronous shadow update. Optional SEG7_LEADING_ZERO_BLANK_EN.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 8,
    parameter int CLKS_PER_DIGIT = 50000,
    parameter int BLANK_CLKS     = 500
) (
    input  logic                  clk,
    input  logic                  rst,
    seg7_scan_ctrl_if.slave       bus,
    output logic [NUM_DIGITS-1:0] o_an,
    output seg_t                  o_seg,
    output logic                  o_dp,
    output logic                  o_frame
);

    localparam int SLOT_W = $clog2(CLKS_PER_DIGIT);
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(CLKS_PER_DIGIT - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [SLOT_W:0]   BLANK_END = (SLOT_W + 1)'(BLANK_CLKS);

    logic [SLOT_W-1:0] slot_p0;
    logic [IDX_W-1:0]  idx_p0;
    logic [PWM_W-1:0]  pwm_p0;

    logic [4*NUM_DIGITS-1:0] active_val, pend_val, commit_val;
    logic [NUM_DIGITS-1:0]   active_dp,  pend_dp,  commit_dp;
    logic [NUM_DIGITS-1:0]   active_en,  pend_en,  commit_en, commit_en_vis;
    logic                    pend_flag;

    logic                  boundary_p0;
    logic                  lit_p0;
    logic [3:0]            nibble_p0;
    seg_t                  seg_p0;
    logic [NUM_DIGITS-1:0] an_p0;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // Keep digits from the most significant nonzero/dp digit downwards.
    function automatic logic [NUM_DIGITS-1:0] lead_keep(
        input logic [4*NUM_DIGITS-1:0] val,
        input logic [NUM_DIGITS-1:0]   dp
    );
        logic [NUM_DIGITS-1:0] keep;
        logic                  seen;
        keep = '0;
        seen = 1'b0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            seen    = seen | (val[4*k +: 4] != 4'h0) | dp[k];
            keep[k] = seen;
        end
        keep[0] = 1'b1;
        return keep;
    endfunction
`endif

    // ---- stage p0: scan counters ----
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_p0 <= '0;
            idx_p0  <= '0;
            pwm_p0  <= '0;
        end else begin
            pwm_p0 <= pwm_p0 + PWM_W'(1);
            if (slot_p0 == SLOT_LAST) begin
                slot_p0 <= '0;
                idx_p0  <= (idx_p0 == IDX_LAST) ? '0 : idx_p0 + IDX_W'(1);
            end else begin
                slot_p0 <= slot_p0 + SLOT_W'(1);
            end
        end
    end

    assign boundary_p0 = (slot_p0 == SLOT_LAST) && (idx_p0 == IDX_LAST);

    // A load landing on the boundary bypasses the shadow and commits directly.
    always_comb begin
        commit_val = pend_val;
        commit_dp  = pend_dp;
        commit_en  = pend_en;
        if (bus.i_load) begin
            commit_val = bus.i_value;
            commit_dp  = bus.i_dp;
            commit_en  = bus.i_digit_en;
        end
    end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    assign commit_en_vis = commit_en & lead_keep(commit_val, commit_dp);
`else
    assign commit_en_vis = commit_en;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            active_val <= '0;
            active_dp  <= '0;
            active_en  <= '0;
            pend_val   <= '0;
            pend_dp    <= '0;
            pend_en    <= '0;
            pend_flag  <= 1'b0;
        end else if (boundary_p0) begin
            if (bus.i_load || pend_flag) begin
                active_val <= commit_val;
                active_dp  <= commit_dp;
                active_en  <= commit_en_vis;
            end
            pend_flag <= 1'b0;
        end else if (bus.i_load) begin
            pend_val  <= bus.i_value;
            pend_dp   <= bus.i_dp;
            pend_en   <= bus.i_digit_en;
            pend_flag <= 1'b1;
        end
    end

    assign lit_p0 = ({1'b0, slot_p0} >= BLANK_END) && active_en[idx_p0]
                    && (pwm_p0 <= bus.i_bright);

    assign nibble_p0 = active_val[{idx_p0, 2'b00} +: 4];

    seg7_hex_decoder u_dec (
        .nibble (nibble_p0),
        .seg    (seg_p0)
    );

    always_comb begin
        an_p0 = '1;
        if (lit_p0) begin
            an_p0[idx_p0] = 1'b0;
        end
    end

    // ---- stage p1: registered pin drivers ----
    always_ff @(posedge clk) begin
        if (rst) begin
            o_an    <= '1;
            o_seg   <= SEG_OFF;
            o_dp    <= 1'b1;
            o_frame <= 1'b0;
        end else begin
            o_an    <= an_p0;
            o_seg   <= lit_p0 ? seg_p0 : SEG_OFF;
            o_dp    <= lit_p0 ? ~active_dp[idx_p0] : 1'b1;
            o_frame <= boundary_p0;
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl: randomized loads against a
// time-indexed behavioural model of the scanner.
module tb_seg7_scan_ctrl;

    localparam int N  = 4;
    localparam int C  = 8;
    localparam int B  = 2;
    localparam int FR = N * C;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seg7_scan_ctrl_if #(.NUM_DIGITS(N)) bus ();

    logic [N-1:0] o_an;
    logic [6:0]   o_seg;
    logic         o_dp;
    logic         o_frame;

    seg7_scan_ctrl #(
        .NUM_DIGITS     (N),
        .CLKS_PER_DIGIT (C),
        .BLANK_CLKS     (B)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .o_an    (o_an),
        .o_seg   (o_seg),
        .o_dp    (o_dp),
        .o_frame (o_frame)
    );

    int checks   = 0;
    int failures = 0;

    logic [6:0] dec [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                             7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

    // Model: t counts cycles since reset release; everything derives from it.
    int          t;
    logic [15:0] m_val, p_val;
    logic [3:0]  m_dp, m_en, p_dp, p_en;
    logic        p_flag;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp, e_frame;

    logic [12:0] obs, exp_v;
    assign obs   = {o_an, o_seg, o_dp, o_frame};
    assign exp_v = {e_an, e_seg, e_dp, e_frame};

    function automatic int dig(input int tt);
        return (tt / C) % N;
    endfunction

    function automatic logic lit(input int tt, input logic [3:0] en, input logic [3:0] br);
        return ((tt % C) >= B) && en[dig(tt)] && ((tt % 16) <= int'(br));
    endfunction

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    function automatic logic [3:0] lzb_en(input logic [15:0] v, input logic [3:0] dp,
                                          input logic [3:0] en);
        int msd;
        msd = 0;
        for (int k = 0; k < N; k++) if (v[4*k +: 4] != 4'h0 || dp[k]) msd = k;
        for (int k = 0; k < N; k++) if (k > msd) en[k] = 1'b0;
        return en;
    endfunction
`endif

    always @(posedge clk) begin
        if (rst) begin
            t <= 0;
            m_val <= '0; m_dp <= '0; m_en <= '0;
            p_val <= '0; p_dp <= '0; p_en <= '0; p_flag <= 1'b0;
            e_an <= 4'hF; e_seg <= 7'h7F; e_dp <= 1'b1; e_frame <= 1'b0;
        end else begin
            t <= t + 1;
            e_an    <= lit(t, m_en, bus.i_bright) ? ~(4'b0001 << dig(t)) : 4'hF;
            e_seg   <= lit(t, m_en, bus.i_bright) ? dec[m_val[4*dig(t) +: 4]] : 7'h7F;
            e_dp    <= lit(t, m_en, bus.i_bright) ? ~m_dp[dig(t)] : 1'b1;
            e_frame <= (t % FR) == FR - 1;
            if ((t % FR) == FR - 1) begin
                if (bus.i_load) begin
                    m_val <= bus.i_value;
                    m_dp  <= bus.i_dp;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
                    m_en  <= lzb_en(bus.i_value, bus.i_dp, bus.i_digit_en);
`else
                    m_en  <= bus.i_digit_en;
`endif
                end else if (p_flag) begin
                    m_val <= p_val;
                    m_dp  <= p_dp;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
                    m_en  <= lzb_en(p_val, p_dp, p_en);
`else
                    m_en  <= p_en;
`endif
                end
                p_flag <= 1'b0;
            end else if (bus.i_load) begin
                p_val  <= bus.i_value;
                p_dp   <= bus.i_dp;
                p_en   <= bus.i_digit_en;
                p_flag <= 1'b1;
            end
        end
    end

    task automatic test_reset();
        int nfr, last;
        nfr = 0; last = 0;
        bus.i_load = 1'b0; bus.i_value = '0; bus.i_dp = '0; bus.i_digit_en = '0;
        bus.i_bright = 4'hF;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (obs !== 13'h1FFE) begin
            failures++; $display("FAIL reset_state got=%h exp=%h", obs, 13'h1FFE);
        end
        rst = 1'b0;
        for (int c = 0; c < 2 * FR; c++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_v) begin
                failures++; $display("FAIL reset_model t=%0d got=%h exp=%h", t, obs, exp_v);
            end
            checks++;
            if ({o_an, o_seg, o_dp} !== {4'hF, 7'h7F, 1'b1}) begin
                failures++; $display("FAIL reset_dark got=%h exp=%h", {o_an, o_seg, o_dp}, 12'hFFF);
            end
            if (o_frame === 1'b1) begin
                if (nfr > 0) begin
                    checks++;
                    if (c - last != FR) begin
                        failures++; $display("FAIL reset_frame_gap got=%0d exp=%0d", c - last, FR);
                    end
                end
                nfr++; last = c;
            end
        end
        checks++;
        if (nfr != 2) begin
            failures++; $display("FAIL reset_frames got=%0d exp=2", nfr);
        end
    endtask

    task automatic test_decode();
        logic [6:0] es [4] = '{7'h60, 7'h08, 7'h12, 7'h4F};
        int cnt [4] = '{0, 0, 0, 0};
        logic found;
        int d;
        found = 1'b0;
        bus.i_value = 16'h12AB; bus.i_dp = 4'b0100; bus.i_digit_en = 4'hF;
        bus.i_bright = 4'hF; bus.i_load = 1'b1;
        for (int c = 0; c < 2 * FR && !found; c++) begin
            @(negedge clk);
            bus.i_load = 1'b0;
            checks++;
            if (obs !== exp_v) begin
                failures++; $display("FAIL decode_model t=%0d got=%h exp=%h", t, obs, exp_v);
            end
            if (o_frame === 1'b1) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++; $display("FAIL decode_frame_timeout got=0 exp=1");
        end
        for (int j = 0; j < FR; j++) begin
            @(negedge clk);
            d = j / C;
            checks++;
            if (obs !== exp_v) begin
                failures++; $display("FAIL decode_model t=%0d got=%h exp=%h", t, obs, exp_v);
            end
            if (o_an !== 4'hF) begin
                cnt[d]++;
                checks++;
                if ({o_an, o_seg, o_dp} !== {~(4'b0001 << d), es[d], (d == 2) ? 1'b0 : 1'b1}) begin
                    failures++;
                    $display("FAIL decode_digit d=%0d got=%h exp=%h", d, {o_an, o_seg, o_dp},
                             {~(4'b0001 << d), es[d], (d == 2) ? 1'b0 : 1'b1});
                end
            end
        end
        for (int k = 0; k < N; k++) begin
            checks++;
            if (cnt[k] != C - B) begin
                failures++; $display("FAIL decode_on_cycles d=%0d got=%0d exp=%0d", k, cnt[k], C - B);
            end
        end
    endtask

    task automatic test_shadow();
        logic found;
        int nlit;
        found = 1'b0; nlit = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            bus.i_load = 1'b0;
            checks++;
            if (obs !== exp_v) begin
                failures++; $display("FAIL shadow_model t=%0d got=%h exp=%h", t, obs, exp_v);
            end
            if (c == 4)  begin bus.i_value = 16'h1111; bus.i_load = 1'b1; end
            if (c == 10) begin bus.i_value = 16'h2222; bus.i_load = 1'b1; end
        end
        for (int c = 0; c < 2 * FR && !found; c++) begin
            @(negedge clk);
            bus.i_load = 1'b0;
            checks++;
            if (obs !== exp_v) begin
                failures++; $display("FAIL shadow_model t=%0d got=%h exp=%h", t, obs, exp_v);
            end
            if (o_frame === 1'b1) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++; $display("FAIL shadow_frame_timeout got=0 exp=1");
        end
        for (int j = 0; j < FR; j++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_v) begin
                failures++; $display("FAIL shadow_model t=%0d got=%h exp=%h", t, obs, exp_v);
            end
            if (o_an !== 4'hF) begin
                nlit++;
                checks++;
                if (o_seg !== 7'h12) begin
                    failures++; $display("FAIL shadow_value got=%h exp=%h", o_seg, 7'h12);
                end
            end
        end
        checks++;
        if (nlit != N * (C - B)) begin
            failures++; $display("FAIL shadow_lit_count got=%0d exp=%0d", nlit, N * (C - B));
        end
    endtask

    task automatic test_coincident();
        logic found;
        int nlit;
        found = 1'b0; nlit = 0;
        bus.i_value = 16'h5555; bus.i_load = 1'b1;
        for (int c = 0; c < 2 * FR && !found; c++) begin
            @(negedge clk);
            bus.i_load = 1'b0;
            checks++;
            if (obs !== exp_v) begin
                failures++; $display("FAIL coinc_model t=%0d got=%h exp=%h", t, obs, exp_v);
            end
            if ((t % FR) == FR - 1) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++; $display("FAIL coinc_align_timeout got=0 exp=1");
        end
        bus.i_value = 16'h3333; bus.i_load = 1'b1;
        @(negedge clk);
        bus.i_load = 1'b0;
        checks++;
        if (obs !== exp_v) begin
            failures++; $display("FAIL coinc_model t=%0d got=%h exp=%h", t, obs, exp_v);
        end
        for (int j = 0; j < 2 * FR; j++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_v) begin
                failures++; $display("FAIL coinc_model t=%0d got=%h exp=%h", t, obs, exp_v);
            end
            if (o_an !== 4'hF) begin
                nlit++;
                checks++;
                if (o_seg !== 7'h06) begin
                    failures++; $display("FAIL coinc_value got=%h exp=%h", o_seg, 7'h06);
                end
            end
        end
        checks++;
        if (nlit != 2 * N * (C - B)) begin
            failures++; $display("FAIL coinc_lit_count got=%0d exp=%0d", nlit, 2 * N * (C - B));
        end
    endtask

    task automatic test_pwm();
        logic found;
        found = 1'b0;
        bus.i_value = 16'($urandom); bus.i_dp = 4'($urandom); bus.i_digit_en = 4'b1010;
        bus.i_bright = 4'h0; bus.i_load = 1'b1;
        for (int c = 0; c < 2 * FR && !found; c++) begin
            @(negedge clk);
            bus.i_load = 1'b0;
            checks++;
            if (obs !== exp_v) begin
                failures++; $display("FAIL pwm_model t=%0d got=%h exp=%h", t, obs, exp_v);
            end
            if (o_frame === 1'b1) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++; $display("FAIL pwm_frame_timeout got=0 exp=1");
        end
        for (int j = 0; j < 2 * FR; j++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_v) begin
                failures++; $display("FAIL pwm_model t=%0d got=%h exp=%h", t, obs, exp_v);
            end
            checks++;
            if (o_an[0] !== 1'b1 || o_an[2] !== 1'b1) begin
                failures++; $display("FAIL pwm_disabled_digit got=%b exp=1x1x", o_an);
            end
        end
    endtask

    task automatic test_random();
        bus.i_bright = 4'($urandom);
        for (int c = 0; c < 20 * FR; c++) begin
            @(negedge clk);
            bus.i_load = 1'b0;
            checks++;
            if (obs !== exp_v) begin
                failures++; $display("FAIL random_model t=%0d got=%h exp=%h", t, obs, exp_v);
            end
            if ($urandom_range(0, 9) == 0) begin
                bus.i_value = 16'($urandom); bus.i_dp = 4'($urandom);
                bus.i_digit_en = 4'($urandom); bus.i_load = 1'b1;
            end
            if ($urandom_range(0, 31) == 0) bus.i_bright = 4'($urandom);
        end
    endtask

    task automatic test_reset_mid();
        bus.i_value = 16'h8888; bus.i_dp = 4'hF; bus.i_digit_en = 4'hF;
        bus.i_bright = 4'hF; bus.i_load = 1'b1;
        repeat (3) begin
            @(negedge clk);
            bus.i_load = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== 13'h1FFE) begin
            failures++; $display("FAIL midreset_dark got=%h exp=%h", obs, 13'h1FFE);
        end
        rst = 1'b0;
        for (int j = 0; j < 2 * FR + 4; j++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_v) begin
                failures++; $display("FAIL midreset_model t=%0d got=%h exp=%h", t, obs, exp_v);
            end
            checks++;
            if (o_an !== 4'hF) begin
                failures++; $display("FAIL midreset_pending_kept got=%h exp=%h", o_an, 4'hF);
            end
        end
    endtask

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    task automatic test_lzb();
        logic found;
        int nlit;
        int d;
        for (int pass = 0; pass < 2; pass++) begin
            found = 1'b0; nlit = 0;
            bus.i_value = (pass == 0) ? 16'h0042 : 16'h0000;
            bus.i_dp = 4'h0; bus.i_digit_en = 4'hF; bus.i_bright = 4'hF; bus.i_load = 1'b1;
            for (int c = 0; c < 2 * FR && !found; c++) begin
                @(negedge clk);
                bus.i_load = 1'b0;
                checks++;
                if (obs !== exp_v) begin
                    failures++; $display("FAIL lzb_model t=%0d got=%h exp=%h", t, obs, exp_v);
                end
                if (o_frame === 1'b1) found = 1'b1;
            end
            checks++;
            if (!found) begin
                failures++; $display("FAIL lzb_frame_timeout got=0 exp=1");
            end
            for (int j = 0; j < FR; j++) begin
                @(negedge clk);
                d = j / C;
                if (o_an !== 4'hF) begin
                    nlit++;
                    checks++;
                    if (pass == 0 && !((d == 1 && o_seg === 7'h4C) || (d == 0 && o_seg === 7'h12))) begin
                        failures++; $display("FAIL lzb_0042 d=%0d got=%h", d, o_seg);
                    end else if (pass == 1 && !(d == 0 && o_seg === 7'h01)) begin
                        failures++; $display("FAIL lzb_0000 d=%0d got=%h exp=%h", d, o_seg, 7'h01);
                    end
                end
            end
            checks++;
            if (nlit != ((pass == 0) ? 2 : 1) * (C - B)) begin
                failures++; $display("FAIL lzb_lit_count got=%0d exp=%0d", nlit,
                                     ((pass == 0) ? 2 : 1) * (C - B));
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_decode();
        test_shadow();
        test_coincident();
        test_pwm();
        test_random();
        test_reset_mid();
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        test_lzb();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
Parametrised multiplexed seven-segment display controller for the Nexys A7 digit bank and similar N-digit boards. It scans NUM_DIGITS common-anode digits with hex decode, per-digit enable and decimal point. It adds inter-digit ghost blanking, PWM brightness, and frame-synchronous (tear-free) value update. It sits in the core clock domain, is driven from a GPIO/register slave, and its outputs go straight to the AN/CA..CG/DP pins.

Parameters:
NUM_DIGITS, 8, number of multiplexed digits (1..16)
CLKS_PER_DIGIT, 50000, clk cycles per digit slot (1 kHz/digit at 50 MHz); must be > BLANK_CLKS + 1
BLANK_CLKS, 500, cycles at the start of each slot with all anodes off (anti-ghosting)

Ports:
clk  in  1  core clock
rst  in  1  synchronous reset, active-high
i_load  in  1  single-cycle strobe; captures i_value/i_dp/i_digit_en into the pending shadow
i_value  in  4*NUM_DIGITS  hex nibble per digit; digit k = i_value[4k+3:4k], digit 0 rightmost
i_dp  in  NUM_DIGITS  decimal point request per digit, active-high
i_digit_en  in  NUM_DIGITS  digit enable per digit, active-high
i_bright  in  4  brightness, live (not shadowed); on-duty = (i_bright+1)/16
o_an  out  NUM_DIGITS  anode selects, active-low, registered
o_seg  out  7  segments {a,b,c,d,e,f,g}, a = MSB, active-low, registered
o_dp  out  1  decimal point, active-low, registered
o_frame  out  1  one-cycle pulse on frame boundary (commit cycle)

Behaviour:
- Reset: o_an all 1, o_seg 7'h7F, o_dp 1, o_frame 0. Slot counter, scan index, PWM counter, active and pending registers all 0; pending flag 0. Display dark until the first commit.
- Slot counter runs 0..CLKS_PER_DIGIT-1 and wraps; on wrap, scan index increments 0..NUM_DIGITS-1 and wraps to 0.
- Frame boundary: the cycle in which slot = CLKS_PER_DIGIT-1 and index = NUM_DIGITS-1. o_frame = 1 in the following cycle (registered).
- Shadow: i_load writes pending and sets the pending flag; a later i_load before commit overwrites pending.
  - At the frame boundary with the flag set: active <= pending; flag cleared.
  - i_load coincident with the boundary: the i_load data commits directly to active and the flag clears.
  - No commit happens without a boundary.
- PWM: 4-bit free-running counter incremented every clk.
- Digit k's anode is driven low when all of these hold: index = k, slot >= BLANK_CLKS, active_en[k] = 1, and pwm <= i_bright. i_bright = 15 gives continuous on. At most one anode is low at any time.
- o_seg = hex decode of active nibble[index]; o_dp = ~active_dp[index]. Both are driven whenever the anode is on, else 7'h7F / 1.
- Decode (active-low): 0=01,1=4F,2=12,3=06,4=4C,5=24,6=20,7=0F,8=00,9=04,A=08,b=60,C=31,d=42,E=30,F=38.
- Latency: outputs are registered one cycle after the counter state that selects them.
- Reset mid-frame: immediate dark, pending discarded.

Optional Feature:
SEG7_LEADING_ZERO_BLANK_EN
- Defined: at commit, compute msd = highest index with a nonzero nibble or dp set (0 if none). Digits above msd are treated as disabled regardless of i_digit_en. Digit 0 is never suppressed.
- Undefined: no suppression; all enabled digits display, including zeros.

Decomposition:
- seg7_pkg: typedef seg_t (logic [6:0]); constant SEG_OFF = 7'h7F; constant HEX2SEG[16] table above; function hex2seg(nibble).
- Sub-module seg7_hex_decoder: combinational nibble -> seg_t using the package table, shared with other display blocks.
- Scan, shadow and PWM logic stay in seg7_scan_ctrl.

Test Plan:
Bench configuration: NUM_DIGITS=4, CLKS_PER_DIGIT=8, BLANK_CLKS=2.
- Reset held, then released with no load -> o_an=4'hF, o_seg=7'h7F, o_dp=1 for two full frames; o_frame pulses every 32 cycles.
- Load value 16'h12Ab, en 4'hF, dp 4'b0100, bright 15 -> after next o_frame each slot shows:
  - digit 0 seg 7'h60
  - digit 1 seg 7'h08
  - digit 2 seg 7'h12, o_dp=0
  - digit 3 seg 7'h4F
  - anode low for exactly 6 of 8 cycles per slot.
- Load 16'h1111 mid-frame, then 16'h2222 before the boundary -> the old value persists until o_frame, then 16'h2222 shows; 16'h1111 never appears.
- i_load coincident with the boundary cycle -> that data visible in the very next frame; pending flag clear.
- bright 0, en 4'b1010 -> digits 0 and 2 anodes never low; digits 1 and 3 low on 1 cycle of every 16 PWM cycles inside their unblanked windows.
- With SEG7_LEADING_ZERO_BLANK_EN, load 16'h0042, en 4'hF -> digits 3 and 2 dark, digits 1 and 0 show 4C/12. Load 16'h0000 -> only digit 0 shows 01.
